mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  - Load/store front-end between the multicycle datapath and the word-only unified Memory.
//  - Handles one request at a time (byte, half or word) and drives Memory's adr, MemRead, MemWrite and WriteData.
//  - Loads: selects the byte lane and sign- or zero-extends the result.
//  - Sub-word stores: done as read-modify-write, because Memory writes whole words only.
// PARAMETERS
//  - AW  32  address width; Memory word index = adr[AW-1:2]
//  - DW  32  data width; fixed at 32, byte lanes little-endian
// PORTS
//  - clk           in   1   system clock; all state changes on posedge
//  - rst           in   1   synchronous, active-low reset
//  - req_valid     in   1   request present
//  - req_ready     out  1   unit idle; request accepted when req_valid & req_ready
//  - req_write     in   1   1 = store, 0 = load
//  - req_size      in   2   00 byte, 01 half, 10 word, 11 treated as word
//  - req_unsigned  in   1   load zero-extends when 1, sign-extends when 0
//  - req_adr       in   32  byte address
//  - req_wdata     in   32  store data, right-justified
//  - resp_valid    out  1   one-cycle completion pulse (loads and stores)
//  - resp_rdata    out  32  extended load data; holds value until next load completes
//  - resp_err      out  1   misalignment flag; qualified by resp_valid
//  - mem_adr       out  32  {adr[31:2],2'b00} of the latched request; 0 in IDLE
//  - mem_read      out  1   MemRead strobe
//  - mem_write     out  1   MemWrite strobe; Memory commits at the posedge ending the cycle
//  - mem_wdata     out  32  WriteData; 0 when mem_write=0
//  - mem_rdata     in   32  ReadData; combinational from Memory
// BEHAVIOUR
//  - Reset (rst=0 at posedge):
//      state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
//      mem_read and mem_write are ANDed with rst, so a reset cycle never writes, even mid-RMW.
//  - Request latch: all req_* fields are captured on accept; inputs are ignored until IDLE.
//  - FSM states: IDLE, ACC, RMW_RD, RMW_WR, RESP, ERR.
//      IDLE -> ACC on accept of a load or word store.
//      IDLE -> RMW_RD on accept of a byte/half store.
//      ACC: mem_read=1 (load, capture mem_rdata) or mem_write=1 with mem_wdata=req_wdata (store); -> RESP.
//      RMW_RD: mem_read=1, capture the old word; -> RMW_WR.
//      RMW_WR: mem_write=1, mem_wdata = old word with the target lane(s) replaced; -> RESP.
//      RESP: resp_valid=1; load result placed on resp_rdata; -> IDLE (req_ready=1 next cycle).
//  - Latency from accept edge to resp_valid:
//      load / word store: 2 cycles;
//      sub-word store: 3 cycles;
//      back-to-back throughput: one request per 3 (or 4) cycles.
//  - Lanes: byte lane = adr[1:0]; half lane = adr[1].
//  - Load extension: byte extends bit 7, half extends bit 15; req_unsigned forces zero-extension.
//  - No backpressure on the response: resp_valid is not held.
//  - Misaligned means: half with adr[0]=1, or word with adr[1:0]!=0.
// CONFIGURATION
//  - MAU_MISALIGN_TRAP_EN defined:
//      a misaligned request goes IDLE -> ERR -> IDLE;
//      ERR: resp_valid=1, resp_err=1, no mem strobes, resp_rdata unchanged.
//  - MAU_MISALIGN_TRAP_EN undefined:
//      ERR state is not built and resp_err is tied 0;
//      low address bits are forced aligned (half clears adr[0], word clears adr[1:0]) and the access proceeds.
// STRUCTURE
//  - Package mau_pkg:
//      state enum;
//      SIZE_BYTE/SIZE_HALF/SIZE_WORD constants;
//      function word_addr().
//  - Sub-module mau_lane_merge (combinational):
//      store merge (old word, wdata, size, offset) -> new word;
//      load extract + extend (word, size, offset, unsigned) -> result.
//  - Top level holds the FSM, request registers and output registers.
// TESTING
//  - Word store 0xDEADBEEF @0x3E8, then word load @0x3E8:
//      mem_write pulses once; load resp_rdata=0xDEADBEEF; resp_valid 2 cycles after each accept.
//  - Mem word @0x400 = 0x11223344; byte store 0xAA @0x402:
//      RMW_RD then RMW_WR; word becomes 0x11AA3344; resp_valid 3 cycles after accept.
//  - Word @0x404 = 0x0000F080:
//      signed byte load @0x404 -> 0xFFFFFF80;
//      unsigned half load @0x404 -> 0x0000F080;
//      signed half load -> 0xFFFFF080.
//  - Half store @0x401:
//      with MAU_MISALIGN_TRAP_EN: resp_err=1 one cycle after accept, zero mem_write pulses;
//      without it: store lands at 0x400, resp_err=0.
//  - rst driven low during the RMW_WR cycle:
//      mem_write stays 0, memory word unchanged;
//      state=IDLE, req_ready=1, resp_valid=0 after the edge.
//  - req_valid held high for 3 loads:
//      each is accepted only in IDLE; exactly 3 resp_valid pulses, in order, none dropped.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory access unit.
// Optional feature: MAU_MISALIGN_TRAP_EN adds the ERR state (misaligned requests trap instead of being aligned).
package mau_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC    = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    RESP   = 3'd4
`ifdef MAU_MISALIGN_TRAP_EN
    , ERR  = 3'd5
`endif
  } state_t;

  function automatic logic [31:0] word_addr(input logic [31:0] adr);
    return {adr[31:2], 2'b00};
  endfunction

  // Size 2'b11 behaves exactly like a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return (off != 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] adr, input logic [1:0] size);
    case (size)
      SIZE_BYTE: return adr;
      SIZE_HALF: return {adr[31:1], 1'b0};
      default:   return {adr[31:2], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/mau_if.sv
// Datapath-side request/response bundle of the memory access unit.
// Handshake: a request transfers on a posedge where req_valid && req_ready; resp_valid is a one-cycle pulse with no backpressure.
interface mau_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_adr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_adr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mau_lane_merge.sv
// Byte-lane logic: merges store data into an old word and extracts/extends load data.
import mau_pkg::*;

module mau_lane_merge (
  input  logic [31:0] oldWord,
  input  logic [31:0] wdata,
  input  logic [31:0] ldWord,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        isUnsigned,
  output logic [31:0] newWord,
  output logic [31:0] ldData
);
  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    newWord = oldWord;
    case (size)
      SIZE_BYTE: newWord[{offset, 3'b000} +: 8]     = wdata[7:0];
      SIZE_HALF: newWord[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default:   newWord = wdata;
    endcase
  end

  always_comb begin
    byteVal = ldWord[{offset, 3'b000} +: 8];
    halfVal = ldWord[{offset[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: ldData = {{24{~isUnsigned & byteVal[7]}}, byteVal};
      SIZE_HALF: ldData = {{16{~isUnsigned & halfVal[15]}}, halfVal};
      default:   ldData = ldWord;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-only memory; sub-word stores run as read-modify-write.
// Optional feature: MAU_MISALIGN_TRAP_EN (trap misaligned requests via ERR instead of aligning them).
import mau_pkg::*;

module mem_access_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  mau_if.slave          bus,
  output logic [AW-1:0] mem_adr,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output state_t        dbgState
);
  state_t      state, stateNext;
  logic        accept;
  logic        reqWrite, reqUnsigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAdr, reqWdata, oldWord, respRdata;
  logic [31:0] newWord, ldData;
  logic        memReadRaw, memWriteRaw;

  assign bus.req_ready = (state == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign dbgState      = state;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MAU_MISALIGN_TRAP_EN
          if (misaligned(bus.req_size, bus.req_adr[1:0])) stateNext = ERR;
          else
`endif
          if (bus.req_write && (bus.req_size == SIZE_BYTE || bus.req_size == SIZE_HALF))
            stateNext = RMW_RD;
          else
            stateNext = ACC;
        end
      end
      ACC:    stateNext = RESP;
      RMW_RD: stateNext = RMW_WR;
      RMW_WR: stateNext = RESP;
      RESP:   stateNext = IDLE;
`ifdef MAU_MISALIGN_TRAP_EN
      ERR:    stateNext = IDLE;
`endif
      default: stateNext = IDLE;
    endcase
  end

  // Strobes are gated by rst so a reset cycle can never commit a write, even mid-RMW.
  always_comb begin
    memReadRaw  = (state == ACC && !reqWrite) || (state == RMW_RD);
    memWriteRaw = (state == ACC && reqWrite) || (state == RMW_WR);
    mem_read    = memReadRaw & rst;
    mem_write   = memWriteRaw & rst;
    mem_adr     = (state == IDLE) ? '0 : word_addr(reqAdr);
    if (!mem_write)           mem_wdata = '0;
    else if (state == RMW_WR) mem_wdata = newWord;
    else                      mem_wdata = reqWdata;
  end

`ifdef MAU_MISALIGN_TRAP_EN
  assign bus.resp_valid = (state == RESP) || (state == ERR);
  assign bus.resp_err   = (state == ERR);
`else
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = 1'b0;
`endif
  assign bus.resp_rdata = respRdata;

  mau_lane_merge u_lane_merge (
    .oldWord    (oldWord),
    .wdata      (reqWdata),
    .ldWord     (mem_rdata),
    .size       (reqSize),
    .offset     (reqAdr[1:0]),
    .isUnsigned (reqUnsigned),
    .newWord    (newWord),
    .ldData     (ldData)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      respRdata   <= '0;
      reqWrite    <= 1'b0;
      reqUnsigned <= 1'b0;
      reqSize     <= SIZE_WORD;
      reqAdr      <= '0;
      reqWdata    <= '0;
      oldWord     <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        reqWrite    <= bus.req_write;
        reqSize     <= bus.req_size;
        reqUnsigned <= bus.req_unsigned;
        reqWdata    <= bus.req_wdata;
`ifdef MAU_MISALIGN_TRAP_EN
        reqAdr      <= bus.req_adr;
`else
        reqAdr      <= align_addr(bus.req_adr, bus.req_size);
`endif
      end
      if (state == RMW_RD) oldWord <= mem_rdata;
      // Captured at the end of ACC so the result is on resp_rdata during RESP.
      if (state == ACC && !reqWrite) respRdata <= ldData;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic against a byte-array reference model.
import mau_pkg::*;

module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mau_if bus();
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  state_t      dbgState;

  mem_access_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_adr   (mem_adr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .dbgState  (dbgState)
  );

  // Word-only memory seen by the DUT (4 KB window).
  logic [31:0] mem_words [0:1023];
  assign mem_rdata = mem_words[mem_adr[11:2]];
  always @(posedge clk) if (mem_write) mem_words[mem_adr[11:2]] <= mem_wdata;

  // Reference model: byte-addressed image, held load result, expected responses {err, rdata}.
  logic [7:0]  ref_bytes [0:4095];
  logic [31:0] exp_rdata_held = 32'h0;
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int resp_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int size_bytes(input int size);
    return (size == 0) ? 1 : (size == 1) ? 2 : 4;
  endfunction

  function automatic bit model_misaligned(input int size, input int adr);
    return (adr % size_bytes(size)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input int size, input bit uns, input int adr);
    int n, ea;
    longint v;
    n = size_bytes(size);
    ea = adr - (adr % n);
    v = 0;
    for (int k = 0; k < n; k++) v += longint'(ref_bytes[ea + k]) << (8 * k);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input int size, input int adr, input logic [31:0] wdata);
    int n, ea;
    logic [31:0] d;
    n = size_bytes(size);
    ea = adr - (adr % n);
    d = wdata;
    for (int k = 0; k < n; k++) begin
      ref_bytes[ea + k] = d[7:0];
      d = d >> 8;
    end
  endtask

  task automatic set_word(input int adr, input logic [31:0] w);
    logic [31:0] d;
    mem_words[adr / 4] = w;
    d = w;
    for (int k = 0; k < 4; k++) begin
      ref_bytes[adr - (adr % 4) + k] = d[7:0];
      d = d >> 8;
    end
  endtask

  // Scoreboard: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && bus.resp_valid) begin
      logic [32:0] e;
      resp_seen++;
      check_eq("resp_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("resp_err", 32'(bus.resp_err), 32'(e[32]));
        check_eq("resp_rdata", bus.resp_rdata, e[31:0]);
      end
    end
    if (mem_read || mem_write) check_eq("mem_adr_hi", 32'(mem_adr[31:12]), 32'd0);
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] adr, input logic [31:0] wdata);
    int exp_lat, exp_writes, lat, writes;
    bit trapped;
    trapped = 1'b0;
`ifdef MAU_MISALIGN_TRAP_EN
    trapped = model_misaligned(int'(size), int'(adr));
`endif
    if (trapped) begin
      exp_lat = 1; exp_writes = 0;
      exp_q.push_back({1'b1, exp_rdata_held});
    end else if (wr) begin
      model_store(int'(size), int'(adr), wdata);
      exp_lat = (size < 2) ? 3 : 2; exp_writes = 1;
      exp_q.push_back({1'b0, exp_rdata_held});
    end else begin
      exp_rdata_held = model_load(int'(size), uns, int'(adr));
      exp_lat = 2; exp_writes = 0;
      exp_q.push_back({1'b0, exp_rdata_held});
    end
    @(negedge clk);
    wait_ready();
    bus.req_write = wr; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_adr = adr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; writes = 0;
    do begin
      @(negedge clk);
      lat++;
      writes += int'(mem_write);
    end while (!bus.resp_valid && lat < 10);
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("mem_write_pulses", 32'(writes), 32'(exp_writes));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b_adr [3];
    logic [1:0]  b2b_size [3];
    logic        b2b_uns [3];
    int          seen0, mism;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_adr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 1024; i++) set_word(i * 4, $urandom);

    // Clock/reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check_eq("rst_mem_strobes", 32'({mem_read, mem_write}), 32'd0);
    check_eq("rst_mem_adr", mem_adr, 32'h0);
    check_eq("rst_state", 32'(dbgState), 32'(IDLE));
    rst = 1'b1;

    // Word store then word load.
    do_req(1'b1, SIZE_WORD, 1'b0, 32'h3E8, 32'hDEADBEEF);
    do_req(1'b0, SIZE_WORD, 1'b0, 32'h3E8, 32'h0);
    check_eq("ld_deadbeef", bus.resp_rdata, 32'hDEADBEEF);

    // Byte store read-modify-write.
    set_word(32'h400, 32'h11223344);
    do_req(1'b1, SIZE_BYTE, 1'b0, 32'h402, 32'h000000AA);
    check_eq("rmw_byte_word", mem_words[32'h400 / 4], 32'h11AA3344);

    // Load extension.
    set_word(32'h404, 32'h0000F080);
    do_req(1'b0, SIZE_BYTE, 1'b0, 32'h404, 32'h0);
    check_eq("ld_sbyte", bus.resp_rdata, 32'hFFFFFF80);
    do_req(1'b0, SIZE_HALF, 1'b1, 32'h404, 32'h0);
    check_eq("ld_uhalf", bus.resp_rdata, 32'h0000F080);
    do_req(1'b0, SIZE_HALF, 1'b0, 32'h404, 32'h0);
    check_eq("ld_shalf", bus.resp_rdata, 32'hFFFFF080);

    // Misaligned half store.
    do_req(1'b1, SIZE_HALF, 1'b0, 32'h401, 32'h00005566);
`ifdef MAU_MISALIGN_TRAP_EN
    check_eq("misaligned_untouched", mem_words[32'h400 / 4], 32'h11AA3344);
`else
    check_eq("misaligned_aligned", mem_words[32'h400 / 4], 32'h11AA5566);
`endif

    // Reset asserted during RMW_WR.
    set_word(32'h408, 32'hCAFEF00D);
    @(negedge clk);
    wait_ready();
    bus.req_write = 1'b1; bus.req_size = SIZE_BYTE; bus.req_unsigned = 1'b0;
    bus.req_adr = 32'h409; bus.req_wdata = 32'h77; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("rmw_rd_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    check_eq("rmw_wr_write", 32'(mem_write), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rst_blocks_write", 32'(mem_write), 32'd0);
    check_eq("rst_wdata_zero", mem_wdata, 32'h0);
    @(negedge clk);
    exp_rdata_held = 32'h0;
    check_eq("rst_mid_state", 32'(dbgState), 32'(IDLE));
    check_eq("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_mid_rdata", bus.resp_rdata, 32'h0);
    check_eq("rst_mid_word", mem_words[32'h408 / 4], 32'hCAFEF00D);
    rst = 1'b1;

    // req_valid held high across three loads.
    b2b_adr[0] = 32'h3E8; b2b_size[0] = SIZE_WORD; b2b_uns[0] = 1'b0;
    b2b_adr[1] = 32'h404; b2b_size[1] = SIZE_BYTE; b2b_uns[1] = 1'b1;
    b2b_adr[2] = 32'h402; b2b_size[2] = SIZE_HALF; b2b_uns[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_rdata_held = model_load(int'(b2b_size[i]), b2b_uns[i], int'(b2b_adr[i]));
      exp_q.push_back({1'b0, exp_rdata_held});
    end
    seen0 = resp_seen;
    @(negedge clk);
    bus.req_write = 1'b0; bus.req_size = b2b_size[0]; bus.req_unsigned = b2b_uns[0];
    bus.req_adr = b2b_adr[0]; bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      @(posedge clk);
      #1;
      if (i < 2) begin
        bus.req_size = b2b_size[i + 1]; bus.req_unsigned = b2b_uns[i + 1];
        bus.req_adr = b2b_adr[i + 1];
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_eq("b2b_resp_count", 32'(resp_seen - seen0), 32'd3);
    check_eq("b2b_queue_drained", 32'(exp_q.size()), 32'd0);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 4095)), $urandom);
    end

    repeat (3) @(negedge clk);
    check_eq("final_queue_drained", 32'(exp_q.size()), 32'd0);
    mism = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem_words[i] !== {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]})
        mism++;
    end
    check_eq("mem_image_mismatches", 32'(mism), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
